// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath types: condition codes, NZCV flag bundle
// and the ALU opcodes the EX/MEM stage needs to interpret carry.
package legv8_pkg;

   typedef enum logic [3:0] {
      C_EQ = 4'b0000,
      C_NE = 4'b0001,
      C_HS = 4'b0010,
      C_LO = 4'b0011,
      C_MI = 4'b0100,
      C_PL = 4'b0101,
      C_VS = 4'b0110,
      C_VC = 4'b0111,
      C_HI = 4'b1000,
      C_LS = 4'b1001,
      C_GE = 4'b1010,
      C_LT = 4'b1011,
      C_GT = 4'b1100,
      C_LE = 4'b1101,
      C_AL = 4'b1110,
      C_NV = 4'b1111
   } cond_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

endpackage

// File: rtl/ex_mem_stage_cond_eval.sv
// B.cond condition evaluator: maps a condition code and the
// NZCV register onto a taken/not-taken decision.
module cond_eval
   import legv8_pkg::*;
(
   input  cond_e cond_i,
   input  nzcv_t flags_i,
   output logic  take_o
);

   logic w_nev;

   assign w_nev = (flags_i.n == flags_i.v);

   always_comb begin
      take_o = 1'b0;
      unique case (cond_i)
         C_EQ: take_o = flags_i.z;
         C_NE: take_o = !flags_i.z;
         C_HS: take_o = flags_i.c;
         C_LO: take_o = !flags_i.c;
         C_MI: take_o = flags_i.n;
         C_PL: take_o = !flags_i.n;
         C_VS: take_o = flags_i.v;
         C_VC: take_o = !flags_i.v;
         C_HI: take_o = flags_i.c & !flags_i.z;
         C_LS: take_o = !flags_i.c | flags_i.z;
         C_GE: take_o = w_nev;
         C_LT: take_o = !w_nev;
         C_GT: take_o = !flags_i.z & w_nev;
         C_LE: take_o = flags_i.z | !w_nev;
         C_AL: take_o = 1'b1;
         C_NV: take_o = 1'b1;
         default: take_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with NZCV flags and branch resolution.
// Define EXMEM_BCOND_EN to build the flags register and B.cond path.
module ex_mem_stage
   import legv8_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int REGW = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic            valid_i,
   input  logic [3:0]      alu_ctrl_i,
   input  logic [XLEN-1:0] result_i,
   input  logic            zero_i,
   input  logic            negative_i,
   input  logic            carry_i,
   input  logic            overflow_i,
   input  logic            set_flags_i,
   input  logic            cbz_i,
   input  logic            cbnz_i,
   input  logic            bcond_i,
   input  logic            uncond_i,
   input  logic [3:0]      cond_i,
   input  logic [XLEN-1:0] branch_target_i,
   input  logic [XLEN-1:0] write_data_i,
   input  logic [REGW-1:0] rd_i,
   input  logic            reg_write_i,
   input  logic            mem_read_i,
   input  logic            mem_write_i,
   input  logic            mem_to_reg_i,
   output logic            valid_o,
   output logic            reg_write_o,
   output logic            mem_read_o,
   output logic            mem_write_o,
   output logic            mem_to_reg_o,
   output logic [XLEN-1:0] result_o,
   output logic [XLEN-1:0] write_data_o,
   output logic [XLEN-1:0] branch_target_o,
   output logic [REGW-1:0] rd_o,
   output logic            pc_src_o,
   output logic [3:0]      flags_o
);

   logic  w_le;
   logic  w_bub;
   logic  w_acc;
   logic  w_take;
   logic  w_cond_take;
   logic  w_bc_take;
   nzcv_t w_flags;

   assign w_le  = !stall_i;
   assign w_bub = flush_i | !valid_i;
   assign w_acc = w_le & !w_bub;

   cond_eval u_cond_eval (
      .cond_i  (cond_e'(cond_i)),
      .flags_i (w_flags),
      .take_o  (w_cond_take)
   );

`ifdef EXMEM_BCOND_EN
   nzcv_t r_flags;
   nzcv_t w_flags_nxt;

   // ALU bit 64 on a subtract is a borrow, so ARM carry is its inverse
   always_comb begin
      w_flags_nxt = r_flags;
      if (w_acc && set_flags_i) begin
         w_flags_nxt.n = negative_i;
         w_flags_nxt.z = zero_i;
         w_flags_nxt.v = overflow_i;
         if (alu_ctrl_i == ALU_ADD)
            w_flags_nxt.c = carry_i;
         else if (alu_ctrl_i == ALU_SUB)
            w_flags_nxt.c = !carry_i;
         else
            w_flags_nxt.c = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_flags <= '0;
      else
         r_flags <= w_flags_nxt;
   end

   assign w_flags   = r_flags;
   assign w_bc_take = w_cond_take;
`else
   logic w_unused;

   assign w_flags   = '0;
   assign w_bc_take = 1'b0;
   assign w_unused  = ^{alu_ctrl_i, set_flags_i, negative_i,
                        carry_i, overflow_i, w_cond_take};
`endif

   assign flags_o = w_flags;

   always_comb begin
      w_take = 1'b0;
      unique case (1'b1)
         uncond_i: w_take = 1'b1;
         cbz_i:    w_take = zero_i;
         cbnz_i:   w_take = !zero_i;
         bcond_i:  w_take = w_bc_take;
         default:  w_take = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_o         <= 1'b0;
         reg_write_o     <= 1'b0;
         mem_read_o      <= 1'b0;
         mem_write_o     <= 1'b0;
         mem_to_reg_o    <= 1'b0;
         pc_src_o        <= 1'b0;
         result_o        <= '0;
         write_data_o    <= '0;
         branch_target_o <= '0;
         rd_o            <= '0;
      end else if (w_le) begin
         if (w_bub) begin
            valid_o      <= 1'b0;
            reg_write_o  <= 1'b0;
            mem_read_o   <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_to_reg_o <= 1'b0;
            pc_src_o     <= 1'b0;
         end else begin
            valid_o         <= 1'b1;
            reg_write_o     <= reg_write_i;
            mem_read_o      <= mem_read_i;
            mem_write_o     <= mem_write_i;
            mem_to_reg_o    <= mem_to_reg_i;
            pc_src_o        <= w_take;
            result_o        <= result_i;
            write_data_o    <= write_data_i;
            branch_target_o <= branch_target_i;
            rd_o            <= rd_i;
         end
      end
   end

endmodule
